// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared types for the decoupled instruction-fetch unit.
//   ifq_entry_t  - one prefetch queue entry (PC + instruction word)
//   ifq_state_t  - fetch request state (idle / keep response / drop response)
//   ibus_req_t   - instruction bus request  (valid, addr)
//   ibus_resp_t  - instruction bus response (addr_ok, data_ok, data)
package ifetch_queue_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction bus between the fetch unit and memory.
//   ireq  - request from fetch unit (valid, addr)
//   iresp - response from memory (addr_ok, data_ok, data)
//   master modport: fetch unit side; slave modport: memory side.
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);
endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: circular prefetch buffer of DEPTH ifq_entry_t, no bus logic.
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_flush      - synchronous flush (empties the queue at the edge)
//   i_push       - write i_push_data at the tail
//   i_pop        - advance the head (ignored when empty)
//   o_head       - entry at the head
//   o_count      - number of occupied entries
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  ifq_entry_t               i_push_data,
  input  logic                     i_pop,
  output ifq_entry_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ifq_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: decoupled instruction fetch with a prefetch queue.
// Keeps one sequential ibus request outstanding while the queue has room,
// buffers {pc, instr}, and hands entries to decode over valid/ready.
// A redirect flushes the queue and restarts fetch; a response already in
// flight at redirect time is consumed and dropped (DROP state).
// Optional feature macro: IFQ_BYPASS_EN (same-cycle data_ok -> deq bypass
// when the queue is empty).
//   clk, rst_n         - clock, asynchronous active-low reset
//   bus                - ifetch_queue_if.master (ireq out, iresp in)
//   i_redirect_valid   - flush and restart at i_redirect_pc
//   i_redirect_pc      - new fetch PC
//   o_deq_valid        - head entry valid
//   i_deq_ready        - decode takes the head this cycle
//   o_deq_pc/instr     - head entry
//   o_count            - occupied entries
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ifetch_queue_if.master         bus,
  input  logic                   i_redirect_valid,
  input  logic [63:0]            i_redirect_pc,
  output logic                   o_deq_valid,
  input  logic                   i_deq_ready,
  output logic [63:0]            o_deq_pc,
  output logic [31:0]            o_deq_instr,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t  r_state,     w_state_nxt;
  logic [63:0] r_fetch_pc,  w_fetch_pc_nxt;
  logic        r_req_valid, w_req_valid_nxt;
  logic [63:0] r_req_addr,  w_req_addr_nxt;

  logic          w_data_ok;
  logic          w_take;
  logic          w_push;
  logic          w_fifo_pop;
  logic [CW:0]   w_occ_nxt;
  logic          w_space;
  ifq_entry_t    w_head;
  ifq_entry_t    w_push_entry;
  logic [CW-1:0] w_count;

  assign w_data_ok    = bus.iresp.data_ok;
  // Response kept for decode: only in WAIT and not killed by a same-cycle redirect.
  assign w_take       = (r_state == IFQ_WAIT) && w_data_ok && !i_redirect_valid;
  assign w_push_entry = '{pc: r_req_addr, instr: bus.iresp.data};

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_take && (w_count == '0);
  assign o_deq_valid = ((w_count != '0) || w_bypass) && !i_redirect_valid;
  assign o_deq_pc    = w_bypass ? r_req_addr : w_head.pc;
  assign o_deq_instr = w_bypass ? bus.iresp.data : w_head.instr;
  assign w_push      = w_take && !(w_bypass && i_deq_ready);
  assign w_fifo_pop  = o_deq_valid && i_deq_ready && !w_bypass;
`else
  assign o_deq_valid = (w_count != '0) && !i_redirect_valid;
  assign o_deq_pc    = w_head.pc;
  assign o_deq_instr = w_head.instr;
  assign w_push      = w_take;
  assign w_fifo_pop  = o_deq_valid && i_deq_ready;
`endif

  // Occupancy after this edge decides whether another request may be issued.
  assign w_occ_nxt = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_fifo_pop};
  assign w_space   = w_occ_nxt < (CW+1)'(DEPTH);

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_fifo_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_req_valid_nxt = r_req_valid;
    w_req_addr_nxt  = r_req_addr;
    unique case (r_state)
      IFQ_IDLE: begin
        if (i_redirect_valid) begin
          w_state_nxt     = IFQ_WAIT;
          w_fetch_pc_nxt  = i_redirect_pc;
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = i_redirect_pc;
        end else if (w_space) begin
          w_state_nxt     = IFQ_WAIT;
          w_req_valid_nxt = 1'b1;
          w_req_addr_nxt  = r_fetch_pc;
        end
      end
      IFQ_WAIT: begin
        if (i_redirect_valid) begin
          w_fetch_pc_nxt = i_redirect_pc;
          if (w_data_ok) begin
            w_req_addr_nxt = i_redirect_pc;
          end else begin
            // Request still in flight: hold addr until its response drains.
            w_state_nxt = IFQ_DROP;
          end
        end else if (w_data_ok) begin
          w_fetch_pc_nxt = r_fetch_pc + 64'd4;
          if (w_space) begin
            w_req_addr_nxt = r_fetch_pc + 64'd4;
          end else begin
            w_state_nxt     = IFQ_IDLE;
            w_req_valid_nxt = 1'b0;
          end
        end
      end
      IFQ_DROP: begin
        if (i_redirect_valid) begin
          w_fetch_pc_nxt = i_redirect_pc;
          if (w_data_ok) begin
            w_state_nxt    = IFQ_WAIT;
            w_req_addr_nxt = i_redirect_pc;
          end
        end else if (w_data_ok) begin
          w_state_nxt    = IFQ_WAIT;
          w_req_addr_nxt = r_fetch_pc;
        end
      end
      default: begin
        w_state_nxt     = IFQ_IDLE;
        w_req_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IFQ_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
    end
  end

  assign bus.ireq = '{valid: r_req_valid, addr: r_req_addr};
  assign o_count  = w_count;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [63:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;
  int mem_lat = 0;
  int wcnt = 0;

  ifetch_queue_if bus ();

  ifetch_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_deq_valid      (deq_valid),
    .i_deq_ready      (deq_ready),
    .o_deq_pc         (deq_pc),
    .o_deq_instr      (deq_instr),
    .o_count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers a held request after mem_lat extra cycles, updated on the falling edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.iresp = '0;
      wcnt = 0;
    end else if (bus.ireq.valid) begin
      if (wcnt >= mem_lat) begin
        bus.iresp.addr_ok = 1'b1;
        bus.iresp.data_ok = 1'b1;
        bus.iresp.data    = mem_data(bus.ireq.addr[31:0]);
        wcnt = 0;
      end else begin
        bus.iresp = '0;
        wcnt = wcnt + 1;
      end
    end else begin
      bus.iresp = '0;
      wcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int lat);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    deq_ready = 1'b0;
    mem_lat = lat;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_chk++; if (bus.ireq.valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %0b want 0", bus.ireq.valid); end
    n_chk++; if (bus.ireq.addr !== 64'd0) begin n_fail++; $display("FAIL reset_req_addr got %h want 0", bus.ireq.addr); end
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid got %0b want 0", deq_valid); end
    n_chk++; if (deq_pc !== 64'd0) begin n_fail++; $display("FAIL reset_deq_pc got %h want 0", deq_pc); end
    n_chk++; if (deq_instr !== 32'd0) begin n_fail++; $display("FAIL reset_deq_instr got %h want 0", deq_instr); end
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_addr;
    logic [63:0] exp_pc;
    apply_reset(0);
    deq_ready = 1'b1;
    step();
    n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE) begin n_fail++; $display("FAIL stream_first_req got v=%0b a=%h want v=1 a=%h", bus.ireq.valid, bus.ireq.addr, BASE); end
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL stream_deq_c1 got %0b want 0", deq_valid); end
    for (int k = 2; k <= 6; k++) begin
      step();
      exp_addr = BASE + 64'(4 * (k - 1));
      exp_pc   = BASE + 64'(4 * (k - 2));
      n_chk++; if (bus.ireq.addr !== exp_addr || bus.ireq.valid !== 1'b1) begin n_fail++; $display("FAIL stream_req_%0d got %h want %h", k, bus.ireq.addr, exp_addr); end
      n_chk++; if (deq_valid !== 1'b1 || deq_pc !== exp_pc) begin n_fail++; $display("FAIL stream_deq_%0d got v=%0b pc=%h want v=1 pc=%h", k, deq_valid, deq_pc, exp_pc); end
      n_chk++; if (deq_instr !== mem_data(exp_pc[31:0])) begin n_fail++; $display("FAIL stream_instr_%0d got %h want %h", k, deq_instr, mem_data(exp_pc[31:0])); end
      n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count_%0d got %0d want 1", k, count); end
    end
  endtask

  task automatic test_fill();
    apply_reset(0);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE + 64'(4 * (k - 1))) begin n_fail++; $display("FAIL fill_req_%0d got v=%0b a=%h", k, bus.ireq.valid, bus.ireq.addr); end
      n_chk++; if (count !== 3'(k - 1)) begin n_fail++; $display("FAIL fill_count_%0d got %0d want %0d", k, count, k - 1); end
    end
    step();
    n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_full_count got %0d want 4", count); end
    n_chk++; if (bus.ireq.valid !== 1'b0) begin n_fail++; $display("FAIL fill_full_req got %0b want 0", bus.ireq.valid); end
    n_chk++; if (deq_valid !== 1'b1 || deq_pc !== BASE) begin n_fail++; $display("FAIL fill_head got v=%0b pc=%h want v=1 pc=%h", deq_valid, deq_pc, BASE); end
    step();
    n_chk++; if (bus.ireq.valid !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL fill_hold got v=%0b cnt=%0d want v=0 cnt=4", bus.ireq.valid, count); end
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0010) begin n_fail++; $display("FAIL fill_refill_req got v=%0b a=%h want v=1 a=80000010", bus.ireq.valid, bus.ireq.addr); end
    n_chk++; if (count !== 3'd3 || deq_pc !== BASE + 64'd4) begin n_fail++; $display("FAIL fill_after_pop got cnt=%0d pc=%h want cnt=3 pc=%h", count, deq_pc, BASE + 64'd4); end
    step();
    n_chk++; if (bus.ireq.valid !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL fill_refull got v=%0b cnt=%0d want v=0 cnt=4", bus.ireq.valid, count); end
    step();
    n_chk++; if (bus.ireq.valid !== 1'b0) begin n_fail++; $display("FAIL fill_single_req got v=%0b want 0", bus.ireq.valid); end
  endtask

  task automatic test_redirect_drop();
    apply_reset(0);
    deq_ready = 1'b1;
    step(); step(); step();
    n_chk++; if (bus.ireq.addr !== BASE + 64'd8) begin n_fail++; $display("FAIL drop_setup_addr got %h want %h", bus.ireq.addr, BASE + 64'd8); end
    mem_lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    #1;
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL drop_deq_forced got %0b want 0", deq_valid); end
    step();
    redirect_valid = 1'b0;
    n_chk++; if (count !== 3'd0 || deq_valid !== 1'b0) begin n_fail++; $display("FAIL drop_flush got cnt=%0d v=%0b want 0/0", count, deq_valid); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== BASE + 64'd8) begin n_fail++; $display("FAIL drop_hold_%0d got v=%0b a=%h want v=1 a=%h", k, bus.ireq.valid, bus.ireq.addr, BASE + 64'd8); end
      if (k < 2) step();
    end
    step();
    n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0100) begin n_fail++; $display("FAIL drop_next_req got v=%0b a=%h want v=1 a=80000100", bus.ireq.valid, bus.ireq.addr); end
    n_chk++; if (count !== 3'd0 || deq_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discarded got cnt=%0d v=%0b want 0/0", count, deq_valid); end
    mem_lat = 0;
    step();
    n_chk++; if (deq_valid !== 1'b1 || deq_pc !== 64'h8000_0100) begin n_fail++; $display("FAIL drop_new_head got v=%0b pc=%h want v=1 pc=80000100", deq_valid, deq_pc); end
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset(0);
    step(); step(); step();
    n_chk++; if (count !== 3'd2 || bus.iresp.data_ok !== 1'b0 && bus.iresp.data_ok !== 1'b1) begin n_fail++; $display("FAIL same_setup_count got %0d want 2", count); end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    deq_ready = 1'b1;
    #5;
    n_chk++; if (bus.iresp.data_ok !== 1'b1) begin n_fail++; $display("FAIL same_setup_dataok got %0b want 1", bus.iresp.data_ok); end
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL same_deq_forced got %0b want 0", deq_valid); end
    step();
    redirect_valid = 1'b0;
    n_chk++; if (count !== 3'd0 || deq_valid !== 1'b0) begin n_fail++; $display("FAIL same_flush got cnt=%0d v=%0b want 0/0", count, deq_valid); end
    n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0400) begin n_fail++; $display("FAIL same_next_req got v=%0b a=%h want v=1 a=80000400", bus.ireq.valid, bus.ireq.addr); end
    step();
    n_chk++; if (deq_valid !== 1'b1 || deq_pc !== 64'h8000_0400 || count !== 3'd1) begin n_fail++; $display("FAIL same_new_head got v=%0b pc=%h cnt=%0d want 1/80000400/1", deq_valid, deq_pc, count); end
  endtask

  task automatic test_double_redirect();
    apply_reset(4);
    deq_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    step();
    redirect_valid = 1'b0;
    n_chk++; if (bus.ireq.addr !== BASE || bus.ireq.valid !== 1'b1) begin n_fail++; $display("FAIL dbl_hold1 got v=%0b a=%h want v=1 a=%h", bus.ireq.valid, bus.ireq.addr, BASE); end
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    step();
    redirect_valid = 1'b0;
    n_chk++; if (bus.ireq.addr !== BASE || bus.ireq.valid !== 1'b1) begin n_fail++; $display("FAIL dbl_hold2 got v=%0b a=%h want v=1 a=%h", bus.ireq.valid, bus.ireq.addr, BASE); end
    mem_lat = 0;
    step();
    n_chk++; if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h300) begin n_fail++; $display("FAIL dbl_next_req got v=%0b a=%h want v=1 a=300", bus.ireq.valid, bus.ireq.addr); end
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL dbl_count got %0d want 0", count); end
    step();
    n_chk++; if (deq_valid !== 1'b1 || deq_pc !== 64'h300) begin n_fail++; $display("FAIL dbl_head got v=%0b pc=%h want v=1 pc=300", deq_valid, deq_pc); end
  endtask

  task automatic test_reset_mid();
    apply_reset(0);
    step(); step(); step();
    n_chk++; if (count !== 3'd2 || bus.ireq.valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup got cnt=%0d v=%0b want 2/1", count, bus.ireq.valid); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.ireq.valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rmid_async got v=%0b cnt=%0d want 0/0", bus.ireq.valid, count); end
    n_chk++; if (deq_valid !== 1'b0 || bus.ireq.addr !== 64'd0) begin n_fail++; $display("FAIL rmid_outputs got v=%0b a=%h want 0/0", deq_valid, bus.ireq.addr); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_double_redirect();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
